// File: rtl/loader_pkg.sv
`default_nettype none
// ==========================================================================
// Module : loader_pkg
// Shared state encoding and defaults for the instruction-memory loader.
// Rev    : 1.0
// ==========================================================================
package loader_pkg;

  localparam int c_depth_default  = 32;
  localparam int c_addr_w_default = 5;
  localparam int c_instr_w        = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ==========================================================================
// Module : instr_mem_loader
// Streams a program into instruction memory, zero-fills the tail and
// releases the CPU from reset once the image is complete.
// Rev    : 1.0
// ==========================================================================
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = c_depth_default,
  parameter int ADDR_W = c_addr_w_default
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 s_valid_i,
  input  logic [c_instr_w-1:0] s_data_i,
  input  logic                 s_last_i,
  output logic                 s_ready_o,
  output logic                 im_we_o,
  output logic [ADDR_W+1:0]    im_addr_o,
  output logic [c_instr_w-1:0] im_data_o,
  output logic                 cpu_rst_n_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ADDR_W:0]      word_cnt_o
);

  localparam logic [ADDR_W:0] c_ptr_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(DEPTH - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_W:0]        r_ptr;
  logic [ADDR_W:0]        w_ptr_next;
  logic [ADDR_W:0]        r_cnt;
  logic [ADDR_W:0]        w_cnt_next;
  logic                   w_hs;
  logic                   w_at_last;
  logic                   w_we;
  logic [c_instr_w-1:0]   w_wdata;

  logic                   r_ready;
  logic                   r_we;
  logic [ADDR_W+1:0]      r_addr;
  logic [c_instr_w-1:0]   r_data;
  logic                   r_run;
  logic                   r_err;

  assign w_hs      = s_valid_i & r_ready;
  assign w_at_last = (r_ptr == c_last_idx);

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_we         = 1'b0;
    w_wdata      = '0;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start_i) begin
          w_state_next = ST_LOAD;
          w_ptr_next   = '0;
          w_cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_we       = 1'b1;
          w_wdata    = s_data_i;
          w_ptr_next = r_ptr + c_ptr_one;
          w_cnt_next = r_cnt + c_ptr_one;
          if (s_last_i) begin
            w_state_next = w_at_last ? ST_RUN : ST_CLEAR;
          end else if (w_at_last) begin
            w_state_next = ST_ERR;
          end
        end
      end
      ST_CLEAR: begin
        w_we       = 1'b1;
        w_ptr_next = r_ptr + c_ptr_one;
        if (w_at_last) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The run flag lags RUN entry by one cycle so the final memory write lands
  // before the CPU leaves reset, yet it drops immediately on a reload request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_run   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_ready <= (w_state_next == ST_LOAD);
      r_we    <= w_we;
      if (w_we) begin
        r_addr <= {r_ptr[ADDR_W-1:0], 2'b00};
        r_data <= w_wdata;
      end
      r_run   <= (r_state == ST_RUN) && (w_state_next == ST_RUN);
      r_err   <= (w_state_next == ST_ERR);
    end
  end

  assign s_ready_o   = r_ready;
  assign im_we_o     = r_we;
  assign im_addr_o   = r_addr;
  assign im_data_o   = r_data;
  assign cpu_rst_n_o = r_run;
  assign done_o      = r_run;
  assign err_o       = r_err;
  assign word_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ==========================================================================
// Module : tb_instr_mem_loader
// Randomized bench for instr_mem_loader against a write-list/timing model.
// Rev    : 1.0
// ==========================================================================
module tb_instr_mem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_i;
  logic              start_i;
  logic              s_valid_i;
  logic [31:0]       s_data_i;
  logic              s_last_i;
  logic              s_ready_o;
  logic              im_we_o;
  logic [ADDR_W+1:0] im_addr_o;
  logic [31:0]       im_data_o;
  logic              cpu_rst_n_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   word_cnt_o;

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .s_valid_i  (s_valid_i),
    .s_data_i   (s_data_i),
    .s_last_i   (s_last_i),
    .s_ready_o  (s_ready_o),
    .im_we_o    (im_we_o),
    .im_addr_o  (im_addr_o),
    .im_data_o  (im_data_o),
    .cpu_rst_n_o(cpu_rst_n_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int t_done  = -1;
  int t_err   = -1;

  logic [31:0]       prog   [DEPTH];
  int                stalls [DEPTH];
  int                hs_cyc [DEPTH];
  logic [ADDR_W+1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                wq_cyc [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; observe registered outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (im_we_o) begin
      wq_addr.push_back(im_addr_o);
      wq_data.push_back(im_data_o);
      wq_cyc.push_back(cyc);
    end
    if (done_o && t_done < 0) t_done = cyc;
    if (err_o && t_err < 0) t_err = cyc;
  endtask

  task automatic rand_prog(input int stall_pct);
    for (int i = 0; i < DEPTH; i++) begin
      prog[i]   = $urandom;
      stalls[i] = ($urandom_range(99) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
    end
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Full load from IDLE/RUN/ERR; start_mid>=0 pulses start alongside that word.
  task automatic do_load(input string name, input int n, input bit with_last, input int start_mid);
    int exp_cnt;
    int exp_done;
    logic [63:0] got;
    logic [63:0] exp;
    clear_q();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    t_done  = -1;
    t_err   = -1;
    check_val({name, ".start_state"},
              {s_ready_o, done_o, cpu_rst_n_o, err_o, word_cnt_o},
              {1'b1, 1'b0, 1'b0, 1'b0, 6'd0});
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < stalls[i]; s++) begin
        s_valid_i = 1'b0;
        s_data_i  = $urandom;
        s_last_i  = 1'($urandom_range(1));
        tick();
      end
      s_valid_i = 1'b1;
      s_data_i  = prog[i];
      s_last_i  = with_last && (i == n - 1);
      if (i == start_mid) start_i = 1'b1;
      hs_cyc[i] = cyc;
      tick();
      start_i = 1'b0;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    check_val({name, ".ready_after_last"}, s_ready_o, 1'b0);
    for (int w = 0; w < DEPTH + 10; w++) begin
      if (with_last ? (t_done >= 0) : (t_err >= 0)) break;
      tick();
    end
    repeat (3) tick();

    exp_cnt = with_last ? DEPTH : n;
    check_val({name, ".wr_count"}, wq_addr.size(), exp_cnt);
    for (int k = 0; k < exp_cnt && k < wq_addr.size(); k++) begin
      got = {16'(wq_cyc[k]), 8'(wq_addr[k]), wq_data[k]};
      exp = {16'((k < n) ? hs_cyc[k] + 1 : hs_cyc[n-1] + 1 + (k - n + 1)),
             8'(k * 4),
             (k < n) ? prog[k] : 32'd0};
      check_val($sformatf("%s.wr%0d", name, k), got, exp);
      if (got !== exp) break;
    end

    if (with_last) begin
      exp_done = hs_cyc[n-1] + (DEPTH - n) + 2;
      check_val({name, ".done_cycle"}, t_done, exp_done);
      check_val({name, ".err_seen"}, t_err, -1);
      check_val({name, ".end_state"},
                {done_o, cpu_rst_n_o, err_o, s_ready_o, word_cnt_o},
                {1'b1, 1'b1, 1'b0, 1'b0, 6'(n)});
    end else begin
      check_val({name, ".err_cycle"}, t_err, hs_cyc[n-1] + 1);
      check_val({name, ".done_seen"}, t_done, -1);
      check_val({name, ".end_state"},
                {done_o, cpu_rst_n_o, err_o, s_ready_o, word_cnt_o},
                {1'b0, 1'b0, 1'b1, 1'b0, 6'(n)});
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    repeat (3) tick();
    check_val("reset_outputs",
              {s_ready_o, im_we_o, im_addr_o, im_data_o, cpu_rst_n_o, done_o, err_o, word_cnt_o}, '0);
    rst_i = 1'b0;
    repeat (2) tick();

    // Directed programs
    for (int i = 0; i < DEPTH; i++) begin
      prog[i]   = $urandom;
      stalls[i] = 0;
    end
    prog[0] = 32'h2001_0005;
    prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820;
    do_load("basic", 3, 1'b1, -1);
    stalls[1] = 2;
    do_load("stall", 3, 1'b1, -1);
    stalls[1] = 0;
    do_load("full", DEPTH, 1'b1, -1);
    do_load("overflow", DEPTH, 1'b0, -1);
    rand_prog(0);
    do_load("after_err", 7, 1'b1, -1);
    rand_prog(20);
    do_load("start_mid", 10, 1'b1, 4);

    // Asynchronous reset while zero-filling
    clear_q();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = $urandom;
      s_last_i  = (i == 2);
      tick();
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    repeat (4) tick();
    check_val("in_clear_we", im_we_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check_val("async_rst_outputs",
              {s_ready_o, im_we_o, im_addr_o, im_data_o, cpu_rst_n_o, done_o, err_o, word_cnt_o}, '0);
    tick();
    rst_i = 1'b0;
    clear_q();
    t_done = -1;
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = $urandom;
      s_last_i  = 1'b1;
      tick();
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    check_val("idle_after_rst",
              {s_ready_o, done_o, cpu_rst_n_o, err_o, 8'(wq_addr.size())}, '0);

    // Randomized loads
    for (int r = 0; r < 12; r++) begin
      int  n;
      bit  last;
      rand_prog(int'($urandom_range(40)));
      last = ($urandom_range(5) != 0);
      n    = last ? int'($urandom_range(DEPTH, 1)) : DEPTH;
      do_load($sformatf("rnd%0d", r), n, last, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
# instr_mem_loader

Synthesizable program loader that writes the instruction memory of `Simple_Single_CPU` from a 32-bit word stream. It holds the CPU in reset while loading and zero-fills unused words, so a fetch past the program's end reads 32'd0. It releases the CPU once memory is consistent. It sits between the host/stream source and the CPU's instruction-memory write port and reset input.

## Interface
Parameters:
- DEPTH, 32: instruction memory depth in words
- ADDR_W, 5: word-address width, log2(DEPTH)

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; asynchronous and active-high
- start_i  in  1  one-cycle pulse; begins a (re)load
- s_valid_i  in  1  stream word valid
- s_data_i  in  32  instruction word
- s_last_i  in  1  marks final word of program, sampled with s_valid_i
- s_ready_o  out  1  loader accepts word
- im_we_o  out  1  instruction-memory write enable
- im_addr_o  out  ADDR_W+2  byte address (word index << 2)
- im_data_o  out  32  write data
- cpu_rst_n_o  out  1  drives CPU rst_n; 0 holds CPU in reset
- done_o  out  1  program loaded, CPU running
- err_o  out  1  overflow: DEPTH words accepted without s_last_i
- word_cnt_o  out  ADDR_W+1  words accepted in current load

## Operation
- States: IDLE, LOAD, CLEAR, RUN, ERR.
- Reset values of all outputs are 0: s_ready_o, im_we_o, im_addr_o, im_data_o, cpu_rst_n_o, done_o, err_o, word_cnt_o. State resets to IDLE and the pointer resets to 0.
- IDLE:
  - start_i -> LOAD with pointer cleared and word_cnt_o cleared.
  - All other inputs are ignored.
- LOAD:
  - s_ready_o=1.
  - Handshake is s_valid_i & s_ready_o. On handshake: write s_data_i at pointer, increment pointer and word_cnt_o.
  - Handshake with s_last_i=1 -> CLEAR, or -> RUN if the pointer reached DEPTH.
  - Handshake at pointer DEPTH-1 with s_last_i=0 -> ERR. That word is still written.
- CLEAR:
  - s_ready_o=0.
  - Writes 32'd0 to each remaining word address, one per cycle, ascending.
  - After the write to DEPTH-1 -> RUN.
- RUN:
  - cpu_rst_n_o=1, done_o=1.
  - start_i -> LOAD. cpu_rst_n_o and done_o drop to 0 the next cycle, and the pointer and word_cnt_o are cleared.
- ERR:
  - err_o=1, cpu_rst_n_o=0.
  - start_i clears err_o and enters LOAD as above.
- start_i during LOAD or CLEAR is ignored.
- Empty programs are not supported; s_last_i is only meaningful with a valid word.
- The pointer is ADDR_W+1 bits, so DEPTH is representable without wrap.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Throughput is one stream word per cycle.
- Write latency: handshake at cycle t gives im_we_o/im_addr_o/im_data_o valid at t+1.
- Zero-fill writes follow the last data write back-to-back, with no idle cycle.
- Load timing: first handshake at cycle 0, N words without stalls, any N in 1..DEPTH.
  - Writes occur on cycles 1..DEPTH.
  - done_o and cpu_rst_n_o rise at cycle DEPTH+1.
  - Source stalls delay this 1:1.
- In the overflow case, err_o rises in the same cycle as the final word's write.
- rst_i mid-operation immediately forces all outputs to reset values, including im_we_o=0 and cpu_rst_n_o=0. A partial image is left in memory; a new start_i is required.

## Structure
- Shared package loader_pkg:
  - state enum (IDLE, LOAD, CLEAR, RUN, ERR)
  - DEPTH/ADDR_W defaults
  - instruction word width constant (32)
- No sub-module: a single FSM with a pointer/counter datapath is natural.
- Instantiated beside Simple_Single_CPU; im_* drives the IM write port, and cpu_rst_n_o drives rst_n.

## Test plan
- Basic load: start, 3 words (0x20010005, 0x20020003, 0x00221820, last on word 3), no stalls.
  - Writes at byte addresses 0, 4, 8, then zeros at 12..124.
  - done_o and cpu_rst_n_o rise at cycle 33; word_cnt_o=3.
- Stalls: same program with s_valid_i low for 2 cycles between words 1 and 2.
  - Same memory image; done_o rises 2 cycles later, at cycle 35.
- Full image: 32 words, last on word 32.
  - No CLEAR writes; RUN at cycle 33; word_cnt_o=32.
- Overflow: 32 words without s_last_i.
  - err_o=1 after the 32nd write; cpu_rst_n_o stays 0; s_ready_o=0.
  - Next start_i clears err_o and accepts a new load.
- Reload and reset:
  - start_i in RUN: cpu_rst_n_o drops next cycle, then reload proceeds.
  - rst_i asserted during CLEAR: all outputs 0 asynchronously, state IDLE.
  - start_i pulsed during LOAD: no effect.
